// File: rtl/gnw_fb_pkg.sv
// Shared constants and types for the framebuffer pixel packer.
// fb_word_t is one DDRAM write: word address, 8 byte lanes, byte enables.
package gnw_fb_pkg;

    localparam logic [28:0] FB_BASE_W         = 29'h6000000;
    localparam int          FB_STRIDE         = 720;
    localparam int          FB_HEIGHT         = 480;
    localparam int          FB_WORDS_PER_LINE = FB_STRIDE / 8;
    localparam int          FIFO_DEPTH        = 4;

    typedef struct packed {
        logic [28:0] addr;
        logic [63:0] data;
        logic [7:0]  be;
    } fb_word_t;

    typedef enum logic {
        OUT_IDLE = 1'b0,
        OUT_REQ  = 1'b1
    } out_state_e;

    function automatic logic [7:0] lane_be(input logic [2:0] lane);
        return 8'b1 << lane;
    endfunction

endpackage

// File: rtl/fb_word_fifo.sv
// Completed-word FIFO with an ordered dual-push port and a single pop.
// Pushes that would exceed DEPTH are dropped and flagged on overflow.
module fb_word_fifo
    import gnw_fb_pkg::*;
#(
    parameter int DEPTH = 4,
    localparam int AW = $clog2(DEPTH),
    localparam int CW = AW + 1
) (
    input  logic          clk_sys,
    input  logic          reset,
    input  logic          push0,
    input  fb_word_t      push0_word,
    input  logic          push1,
    input  fb_word_t      push1_word,
    input  logic          pop,
    output fb_word_t      head,
    output logic [CW-1:0] count,
    output logic          empty,
    output logic          overflow
);

    localparam int FW = AW + 2;
    localparam logic [FW-1:0] DEPTH_L = FW'(DEPTH);

    fb_word_t      mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] w1_ptr;
    logic          do_pop;
    logic [FW-1:0] fill_next;

    assign empty  = (count == '0);
    assign do_pop = pop & ~empty;
    assign head   = mem[rd_ptr];
    assign w1_ptr = wr_ptr + AW'(push0);

    assign fill_next = {1'b0, count}
                     + FW'(push0)
                     + FW'(push1)
                     - FW'(do_pop);

    assign overflow = (fill_next > DEPTH_L);

    always_ff @(posedge clk_sys) begin
        if (!overflow) begin
            if (push0) mem[wr_ptr] <= push0_word;
            if (push1) mem[w1_ptr] <= push1_word;
        end
    end

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_pop) rd_ptr <= rd_ptr + AW'(1);
            if (!overflow) begin
                wr_ptr <= wr_ptr + AW'(push0) + AW'(push1);
                count  <= fill_next[CW-1:0];
            end else begin
                count  <= count - CW'(do_pop);
            end
        end
    end

endmodule

// File: rtl/fb_pixel_packer.sv
// Merges raster-order 8-bit pixels into 64-bit DDRAM words and issues
// them on a level-held req / one-cycle ready write channel.
module fb_pixel_packer #(
    parameter logic [28:0] FB_BASE_W  = gnw_fb_pkg::FB_BASE_W,
    parameter int          FB_STRIDE  = gnw_fb_pkg::FB_STRIDE,
    parameter int          FB_HEIGHT  = gnw_fb_pkg::FB_HEIGHT,
    parameter int          FIFO_DEPTH = gnw_fb_pkg::FIFO_DEPTH
) (
    input  logic        clk_sys,
    input  logic        reset,
    input  logic        pix_valid,
    output logic        pix_ready,
    input  logic [9:0]  pix_x,
    input  logic [8:0]  pix_y,
    input  logic [7:0]  pix_color,
    input  logic        flush,
    input  logic        frame_start,
    output logic [28:0] fb_addr,
    output logic [63:0] fb_data,
    output logic [7:0]  fb_be,
    output logic        fb_req,
    input  logic        fb_ready,
    output logic        busy,
    output logic [15:0] words_written
);

    import gnw_fb_pkg::*;

    localparam int          CW        = $clog2(FIFO_DEPTH) + 1;
    localparam logic [28:0] WPL       = 29'(FB_STRIDE / 8);
    localparam logic [10:0] X_LIM     = 11'(FB_STRIDE);
    localparam logic [9:0]  Y_LIM     = 10'(FB_HEIGHT);
    localparam logic [CW-1:0] RDY_MAX = CW'(FIFO_DEPTH - 2);

    fb_word_t      open_w;
    logic          open_v;
    fb_word_t      merged;
    logic          merged_v;
    logic          push_old;
    logic          push_new;

    logic          pix_in_range;
    logic          pix_acc;
    logic [28:0]   pix_addr;
    logic [2:0]    lane;
    logic          addr_hit;

    logic          fifo_push0;
    logic          fifo_push1;
    fb_word_t      fifo_push0_word;
    fb_word_t      fifo_head;
    logic [CW-1:0] fifo_count;
    logic          fifo_empty;
    logic          fifo_ovf;
    logic          fifo_pop;
    logic          ovf_q;

    out_state_e    state_q;
    out_state_e    state_d;
    logic          load_head;

    assign pix_in_range = ({1'b0, pix_x} < X_LIM) & ({1'b0, pix_y} < Y_LIM);
    assign pix_addr     = FB_BASE_W + 29'(pix_y) * WPL + 29'(pix_x[9:3]);
    assign lane         = pix_x[2:0];

    // Two free slots guarantee room for old-word plus completed-word push.
    assign pix_ready = ~reset & (fifo_count <= RDY_MAX);
    assign pix_acc   = pix_valid & pix_ready & pix_in_range;
    assign addr_hit  = open_v & (open_w.addr == pix_addr);

    always_comb begin
        merged   = open_w;
        merged_v = open_v;
        push_old = 1'b0;
        if (pix_acc) begin
            if (!addr_hit) begin
                push_old    = open_v;
                merged.addr = pix_addr;
                merged.data = '0;
                merged.be   = '0;
            end
            merged.data[{lane, 3'b000} +: 8] = pix_color;
            merged.be = merged.be | lane_be(lane);
            merged_v  = 1'b1;
        end
        push_new = merged_v & ((merged.be == 8'hFF) | flush | frame_start);
    end

    assign fifo_push0      = push_old | push_new;
    assign fifo_push1      = push_old & push_new;
    assign fifo_push0_word = push_old ? open_w : merged;

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            open_v <= 1'b0;
            open_w <= '0;
        end else begin
            open_v <= merged_v & ~push_new;
            open_w <= merged;
        end
    end

    fb_word_fifo #(
        .DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clk_sys   (clk_sys),
        .reset     (reset),
        .push0     (fifo_push0),
        .push0_word(fifo_push0_word),
        .push1     (fifo_push1),
        .push1_word(merged),
        .pop       (fifo_pop),
        .head      (fifo_head),
        .count     (fifo_count),
        .empty     (fifo_empty),
        .overflow  (fifo_ovf)
    );

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            ovf_q <= 1'b0;
        end else if (fifo_ovf) begin
            ovf_q <= 1'b1;
        end else if (frame_start) begin
            ovf_q <= 1'b0;
        end
    end

    assert property (@(posedge clk_sys) disable iff (reset) !(fifo_ovf || ovf_q))
        else $error("fb_word_fifo pushed while full");

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            state_q <= OUT_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            OUT_IDLE: if (!fifo_empty) state_d = OUT_REQ;
            OUT_REQ:  if (fb_ready)    state_d = OUT_IDLE;
            default:  state_d = OUT_IDLE;
        endcase
    end

    always_comb begin
        fb_req    = 1'b0;
        load_head = 1'b0;
        fifo_pop  = 1'b0;
        unique case (state_q)
            OUT_IDLE: load_head = ~fifo_empty;
            OUT_REQ: begin
                fb_req   = 1'b1;
                fifo_pop = fb_ready;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            fb_addr       <= '0;
            fb_data       <= '0;
            fb_be         <= '0;
            words_written <= '0;
        end else begin
            if (load_head) begin
                fb_addr <= fifo_head.addr;
                fb_data <= fifo_head.data;
                fb_be   <= fifo_head.be;
            end
            if (fifo_pop) words_written <= words_written + 16'd1;
        end
    end

    assign busy = open_v | ~fifo_empty | fb_req;

endmodule

// File: tb/tb_fb_pixel_packer.sv
// Self-checking bench for fb_pixel_packer: directed sequences, a vector
// table and a randomized stream against a queue-based reference model.
module tb_fb_pixel_packer;

    logic        clk_sys = 1'b0;
    logic        reset = 1'b1;
    logic        pix_valid = 1'b0;
    logic        pix_ready;
    logic [9:0]  pix_x = '0;
    logic [8:0]  pix_y = '0;
    logic [7:0]  pix_color = '0;
    logic        flush = 1'b0;
    logic        frame_start = 1'b0;
    logic [28:0] fb_addr;
    logic [63:0] fb_data;
    logic [7:0]  fb_be;
    logic        fb_req;
    logic        fb_ready = 1'b0;
    logic        busy;
    logic [15:0] words_written;

    always #5 clk_sys = ~clk_sys;

    fb_pixel_packer dut (
        .clk_sys      (clk_sys),
        .reset        (reset),
        .pix_valid    (pix_valid),
        .pix_ready    (pix_ready),
        .pix_x        (pix_x),
        .pix_y        (pix_y),
        .pix_color    (pix_color),
        .flush        (flush),
        .frame_start  (frame_start),
        .fb_addr      (fb_addr),
        .fb_data      (fb_data),
        .fb_be        (fb_be),
        .fb_req       (fb_req),
        .fb_ready     (fb_ready),
        .busy         (busy),
        .words_written(words_written)
    );

    typedef struct {
        logic [28:0] addr;
        logic [63:0] data;
        logic [7:0]  be;
    } word_t;

    typedef struct {
        int          x;
        int          y;
        logic [7:0]  c;
        logic [28:0] addr;
        logic [7:0]  be;
    } vec_t;

    int    n_cmp = 0;
    int    n_bad = 0;
    int    exp_ww = 0;
    int    acc_cnt = 0;
    word_t exp_q[$];
    logic        m_v = 1'b0;
    logic [28:0] m_a;
    logic [63:0] m_d;
    logic [7:0]  m_be;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %0h, required %0h", name, act, req);
        end
    endtask

    function automatic logic [28:0] ref_addr(input int x, input int y);
        return 29'(32'h6000000 + y * (720 / 8) + x / 8);
    endfunction

    function automatic logic [7:0] byte_at(input logic [63:0] d, input int lane);
        return 8'(d >> (8 * lane));
    endfunction

    task automatic send_pix(input int x, input int y, input logic [7:0] c);
        int n = 0;
        pix_valid = 1'b1;
        pix_x = 10'(x);
        pix_y = 9'(y);
        pix_color = c;
        while (!pix_ready && n < 400) begin
            @(negedge clk_sys);
            n++;
        end
        if (!pix_ready) chk("pix_ready_timeout", 0, 1);
        else acc_cnt++;
        @(negedge clk_sys);
        pix_valid = 1'b0;
    endtask

    task automatic pulse_flush(input bit fs);
        if (fs) frame_start = 1'b1;
        else flush = 1'b1;
        @(negedge clk_sys);
        flush = 1'b0;
        frame_start = 1'b0;
    endtask

    task automatic wait_req(input string name);
        int n = 0;
        while (!fb_req && n < 200) begin
            @(negedge clk_sys);
            n++;
        end
        if (!fb_req) chk(name, 0, 1);
    endtask

    task automatic ack();
        fb_ready = 1'b1;
        @(negedge clk_sys);
        fb_ready = 1'b0;
        exp_ww++;
    endtask

    task automatic model_push();
        word_t w;
        w.addr = m_a;
        w.data = m_d;
        w.be = m_be;
        exp_q.push_back(w);
        m_v = 1'b0;
    endtask

    task automatic model_pixel(input int x, input int y, input logic [7:0] c);
        logic [28:0] a;
        if (x >= 720 || y >= 480) return;
        a = ref_addr(x, y);
        if (!(m_v && m_a == a)) begin
            if (m_v) model_push();
            m_v = 1'b1;
            m_a = a;
            m_d = '0;
            m_be = '0;
        end
        m_d[(x % 8) * 8 +: 8] = c;
        m_be[x % 8] = 1'b1;
        if (m_be == 8'hFF) model_push();
    endtask

    task automatic handshake();
        word_t e;
        logic [63:0] mask;
        if (exp_q.size() == 0) begin
            chk("rnd_unexpected_word", 1, 0);
        end else begin
            e = exp_q.pop_front();
            mask = '0;
            for (int k = 0; k < 8; k++) if (e.be[k]) mask[k*8 +: 8] = 8'hFF;
            chk("rnd_addr", fb_addr, e.addr);
            chk("rnd_be", fb_be, e.be);
            chk("rnd_data", fb_data & mask, e.data & mask);
        end
        exp_ww++;
    endtask

    vec_t vecs[6];

    initial begin
        vecs[0] = '{x: 0,   y: 0,   c: 8'h5A, addr: 29'h6000000, be: 8'h01};
        vecs[1] = '{x: 7,   y: 0,   c: 8'hC3, addr: 29'h6000000, be: 8'h80};
        vecs[2] = '{x: 8,   y: 1,   c: 8'h01, addr: 29'h600005B, be: 8'h01};
        vecs[3] = '{x: 100, y: 10,  c: 8'h7E, addr: 29'h6000390, be: 8'h10};
        vecs[4] = '{x: 360, y: 240, c: 8'hE1, addr: 29'h600548D, be: 8'h01};
        vecs[5] = '{x: 719, y: 479, c: 8'hFF, addr: 29'h600A8BF, be: 8'h80};

        repeat (3) @(negedge clk_sys);
        chk("rst_pix_ready", pix_ready, 0);
        chk("rst_fb_req", fb_req, 0);
        chk("rst_fb_addr", fb_addr, 0);
        chk("rst_fb_data", fb_data, 0);
        chk("rst_fb_be", fb_be, 0);
        chk("rst_busy", busy, 0);
        chk("rst_ww", words_written, 0);
        reset = 1'b0;
        @(negedge clk_sys);
        chk("rel_pix_ready", pix_ready, 1);

        // Full word, acknowledged three cycles after the request.
        for (int x = 0; x < 8; x++) send_pix(x, 0, 8'(8'h10 + x));
        wait_req("t1_req");
        repeat (3) @(negedge clk_sys);
        chk("t1_req_held", fb_req, 1);
        chk("t1_addr", fb_addr, 29'h6000000);
        chk("t1_data", fb_data, 64'h1716151413121110);
        chk("t1_be", fb_be, 8'hFF);
        ack();
        chk("t1_ww", words_written, 16'(exp_ww));
        chk("t1_req_drop", fb_req, 0);
        chk("t1_busy", busy, 0);

        // Partial word closed by frame_start.
        for (int x = 16; x < 19; x++) send_pix(x, 2, 8'hAA);
        pulse_flush(1'b1);
        wait_req("t2_req");
        chk("t2_addr", fb_addr, 29'h60000B6);
        chk("t2_be", fb_be, 8'h07);
        chk("t2_data", fb_data[23:0], 24'hAAAAAA);
        ack();
        chk("t2_ww", words_written, 16'(exp_ww));

        // Address change pushes the old word, flush pushes the new one.
        send_pix(5, 0, 8'h01);
        send_pix(13, 0, 8'h02);
        pulse_flush(1'b0);
        wait_req("t3_req0");
        chk("t3_addr0", fb_addr, 29'h6000000);
        chk("t3_be0", fb_be, 8'h20);
        chk("t3_byte0", fb_data[47:40], 8'h01);
        ack();
        wait_req("t3_req1");
        chk("t3_addr1", fb_addr, 29'h6000001);
        chk("t3_be1", fb_be, 8'h20);
        chk("t3_byte1", fb_data[47:40], 8'h02);
        ack();
        chk("t3_ww", words_written, 16'(exp_ww));

        // Same lane written twice: last value wins.
        send_pix(3, 0, 8'h11);
        send_pix(3, 0, 8'h22);
        pulse_flush(1'b0);
        wait_req("ow_req");
        chk("ow_be", fb_be, 8'h08);
        chk("ow_byte", fb_data[31:24], 8'h22);
        ack();

        // Out-of-range pixels are accepted and dropped.
        send_pix(720, 0, 8'h33);
        send_pix(0, 480, 8'h44);
        send_pix(1023, 511, 8'h55);
        repeat (5) @(negedge clk_sys);
        chk("oor_req", fb_req, 0);
        chk("oor_busy", busy, 0);
        pulse_flush(1'b0);
        repeat (4) @(negedge clk_sys);
        chk("oor_flush_req", fb_req, 0);
        chk("oor_flush_busy", busy, 0);

        for (int i = 0; i < 6; i++) begin
            send_pix(vecs[i].x, vecs[i].y, vecs[i].c);
            pulse_flush(1'b0);
            wait_req($sformatf("vec%0d_req", i));
            chk($sformatf("vec%0d_addr", i), fb_addr, vecs[i].addr);
            chk($sformatf("vec%0d_be", i), fb_be, vecs[i].be);
            chk($sformatf("vec%0d_byte", i), byte_at(fb_data, vecs[i].x % 8), vecs[i].c);
            ack();
        end
        chk("vec_ww", words_written, 16'(exp_ww));

        // Backpressure: 40 pixels with fb_ready held low at first.
        acc_cnt = 0;
        fork
            begin
                for (int x = 0; x < 40; x++) send_pix(x, 1, 8'(x));
            end
            begin
                bit seen = 0;
                for (int n = 0; n < 60; n++) begin
                    if (!pix_ready && !seen) begin
                        seen = 1;
                        chk("bp_accepted_at_stall", acc_cnt, 24);
                    end
                    @(negedge clk_sys);
                end
                chk("bp_ready_fell", seen, 1);
                chk("bp_still_stalled", pix_ready, 0);
                for (int k = 0; k < 5; k++) begin
                    logic [63:0] d;
                    for (int j = 0; j < 8; j++) d[j*8 +: 8] = 8'(8 * k + j);
                    wait_req($sformatf("bp_req%0d", k));
                    chk($sformatf("bp_addr%0d", k), fb_addr, 29'(32'h6000000 + 90 + k));
                    chk($sformatf("bp_be%0d", k), fb_be, 8'hFF);
                    chk($sformatf("bp_data%0d", k), fb_data, d);
                    ack();
                end
            end
        join
        chk("bp_ww", words_written, 16'(exp_ww));
        chk("bp_busy", busy, 0);

        // Randomized stream against the reference model.
        for (int cyc = 0; cyc < 3000; cyc++) begin
            int x;
            int y;
            logic [7:0] c;
            x = $urandom_range(0, 31);
            y = $urandom_range(0, 2);
            if ($urandom_range(0, 15) == 0) x = 720 + $urandom_range(0, 303);
            if ($urandom_range(0, 15) == 0) y = 480 + $urandom_range(0, 31);
            c = 8'($urandom);
            pix_valid = ($urandom_range(0, 3) != 0);
            pix_x = 10'(x);
            pix_y = 9'(y);
            pix_color = c;
            flush = ($urandom_range(0, 9) == 0);
            frame_start = ($urandom_range(0, 19) == 0);
            fb_ready = 1'($urandom_range(0, 1));
            if (fb_req && fb_ready) handshake();
            if (pix_valid && pix_ready) model_pixel(x, y, c);
            if ((flush || frame_start) && m_v) model_push();
            @(negedge clk_sys);
        end
        pix_valid = 1'b0;
        frame_start = 1'b0;
        flush = 1'b1;
        if (m_v) model_push();
        for (int n = 0; n < 2000 && (exp_q.size() != 0 || busy); n++) begin
            fb_ready = 1'($urandom_range(0, 1));
            if (fb_req && fb_ready) handshake();
            @(negedge clk_sys);
            flush = 1'b0;
        end
        flush = 1'b0;
        fb_ready = 1'b0;
        chk("rnd_drained", exp_q.size(), 0);
        chk("rnd_busy", busy, 0);
        chk("rnd_ww", words_written, 16'(exp_ww));

        // Reset while a request is pending discards it.
        for (int x = 0; x < 8; x++) send_pix(x, 3, 8'(8'h40 + x));
        wait_req("rq_req");
        reset = 1'b1;
        #1;
        exp_ww = 0;
        chk("rq_req_drop", fb_req, 0);
        chk("rq_busy", busy, 0);
        chk("rq_ww", words_written, 0);
        chk("rq_pix_ready", pix_ready, 0);
        chk("rq_be", fb_be, 0);
        @(negedge clk_sys);
        reset = 1'b0;
        repeat (6) @(negedge clk_sys);
        chk("rq_no_retry", fb_req, 0);
        chk("rq_idle_busy", busy, 0);
        for (int x = 8; x < 16; x++) send_pix(x, 4, 8'(8'h80 + x - 8));
        wait_req("rq_fresh_req");
        chk("rq_fresh_addr", fb_addr, 29'h6000169);
        chk("rq_fresh_data", fb_data, 64'h8786858483828180);
        chk("rq_fresh_be", fb_be, 8'hFF);
        ack();
        chk("rq_fresh_ww", words_written, 16'(exp_ww));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
